// File: rtl/mem_writeback_pkg.sv
// Shared types for the memory/writeback stage: data block, address, FSM state.
package mem_writeback_pkg;
  localparam int DATA_W         = 16;
  localparam int REG_ADDR_W     = 4;
  localparam int DMEM_DEPTH_DEF = 256;

  typedef logic [DATA_W-1:0]     block_t;
  typedef logic [DATA_W-1:0]     addr_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_RUN    = 2'd1,
    WB_HALTED = 2'd2
  } wb_state_t;
endpackage

// File: rtl/mem_writeback_data_memory.sv
// Single-port data memory: synchronous read (old data on a same-address write), no reset.
module data_memory
  import mem_writeback_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  block_t                   i_wdata,
  output block_t                   o_rdata
);
  block_t r_mem [DEPTH];
  block_t r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_writeback.sv
// Memory/writeback stage: one entry per cycle, loads/stores against data_memory,
// one-cycle registered writeback to the register file, saturating retire counter.
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  block_t                result,
  input  logic                  do_exe_reg_write,
  input  reg_addr_t             exe_reg_addr,
  input  logic                  is_mem_read,
  input  logic                  is_mem_write,
  input  block_t                store_value,
  input  logic                  do_branch,
  input  logic                  do_halt,
  output logic                  reg_we,
  output reg_addr_t             reg_waddr,
  output block_t                reg_wdata,
  output block_t                mem_value,
  output logic                  is_mem_data_hazard,
  output logic                  wb_halted,
  output logic [CNT_W-1:0]      retired_count
);
  localparam int AW = $clog2(DMEM_DEPTH);

  wb_state_t        r_state, w_next;
  logic             w_proc, w_mem_we, w_load_wr, w_alu_wr, w_retire;
  block_t           w_rdata;
  logic             r_we, r_load;
  reg_addr_t        r_waddr;
  block_t           r_val;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WB_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WB_IDLE:   if (!do_halt) w_next = WB_RUN;
      WB_RUN:    if (do_halt)  w_next = WB_HALTED;
      WB_HALTED: w_next = WB_HALTED;
      default:   w_next = WB_IDLE;
    endcase
  end

  // The entry at an edge is consumed only while not halting; the IDLE->RUN edge counts.
  always_comb begin
    w_proc    = (r_state != WB_HALTED) && !do_halt;
    wb_halted = (r_state == WB_HALTED);
  end

  assign w_mem_we  = w_proc & is_mem_write & ~do_branch;
  assign w_load_wr = w_proc & is_mem_read & ~is_mem_write & ~do_branch & do_exe_reg_write;
  assign w_alu_wr  = w_proc & ~is_mem_read & ~is_mem_write & ~do_branch & do_exe_reg_write;
  assign w_retire  = w_proc & (is_mem_write | do_exe_reg_write | do_branch);

  data_memory #(.DEPTH(DMEM_DEPTH)) u_dmem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (result[AW-1:0]),
    .i_wdata (store_value),
    .o_rdata (w_rdata)
  );

  // Load data arrives straight from the RAM output register; r_val captures it one
  // edge later so mem_value holds, and reset can clear mem_value without touching the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_load  <= 1'b0;
      r_waddr <= '0;
      r_val   <= '0;
      r_cnt   <= '0;
    end else begin
      r_we   <= w_load_wr | w_alu_wr;
      r_load <= w_load_wr;
      if (w_load_wr | w_alu_wr) r_waddr <= exe_reg_addr;
      if (w_alu_wr)    r_val <= result;
      else if (r_load) r_val <= w_rdata;
      if (w_retire && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign mem_value          = r_load ? w_rdata : r_val;
  assign reg_wdata          = mem_value;
  assign reg_we             = r_we;
  assign reg_waddr          = r_waddr;
  assign is_mem_data_hazard = r_load;
  assign retired_count      = r_cnt;
endmodule

// File: tb/tb_mem_writeback.sv
// Directed + random bench for mem_writeback against a behavioural entry-level model.
module tb_mem_writeback;
  localparam int CNT_W = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0, clk_run = 1'b1, rst;
  logic [15:0] result, store_value;
  logic do_exe_reg_write, is_mem_read, is_mem_write, do_branch, do_halt;
  logic [3:0] exe_reg_addr;
  logic reg_we, is_mem_data_hazard, wb_halted;
  logic [3:0] reg_waddr;
  logic [15:0] reg_wdata, mem_value;
  logic [CNT_W-1:0] retired_count;

  int checks = 0, errors = 0;

  // behavioural model
  logic [15:0] m_mem [DEPTH];
  bit          m_halted, m_running;
  bit          m_we, m_haz;
  logic [3:0]  m_waddr;
  logic [15:0] m_val;
  int          m_cnt;

  mem_writeback #(.DMEM_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .result(result), .do_exe_reg_write(do_exe_reg_write),
    .exe_reg_addr(exe_reg_addr), .is_mem_read(is_mem_read), .is_mem_write(is_mem_write),
    .store_value(store_value), .do_branch(do_branch), .do_halt(do_halt),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .mem_value(mem_value),
    .is_mem_data_hazard(is_mem_data_hazard), .wb_halted(wb_halted),
    .retired_count(retired_count)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".reg_we"}, 32'(reg_we), 32'(m_we));
    if (m_we) begin
      chk({tag, ".reg_waddr"}, 32'(reg_waddr), 32'(m_waddr));
      chk({tag, ".reg_wdata"}, 32'(reg_wdata), 32'(m_val));
    end
    chk({tag, ".mem_value"}, 32'(mem_value), 32'(m_val));
    chk({tag, ".hazard"}, 32'(is_mem_data_hazard), 32'(m_haz));
    chk({tag, ".halted"}, 32'(wb_halted), 32'(m_halted));
    chk({tag, ".count"}, 32'(retired_count), 32'(m_cnt));
  endtask

  function automatic void model_reset();
    m_halted = 0; m_running = 0; m_we = 0; m_haz = 0; m_waddr = '0; m_val = '0; m_cnt = 0;
  endfunction

  // One edge of the pipeline at the entry level: what a retiring instruction does.
  function automatic void model_edge();
    int a;
    bit consumed;
    consumed = !m_halted && !do_halt;
    if (!m_halted && do_halt && m_running) m_halted = 1;
    if (consumed) m_running = 1;
    m_we = 0; m_haz = 0;
    if (!consumed) return;
    a = int'(result) % DEPTH;
    if (do_branch) begin
    end else if (is_mem_write) begin
      m_mem[a] = store_value;
    end else if (is_mem_read) begin
      if (do_exe_reg_write) begin
        m_we = 1; m_haz = 1; m_waddr = exe_reg_addr; m_val = m_mem[a];
      end
    end else if (do_exe_reg_write) begin
      m_we = 1; m_waddr = exe_reg_addr; m_val = result;
    end
    if ((is_mem_write || do_exe_reg_write || do_branch) && m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endfunction

  task automatic step(input string tag, input bit h, input bit rw, input logic [3:0] rd,
                      input bit mr, input bit mw, input bit br,
                      input logic [15:0] res, input logic [15:0] sv);
    do_halt = h; do_exe_reg_write = rw; exe_reg_addr = rd; is_mem_read = mr;
    is_mem_write = mw; do_branch = br; result = res; store_value = sv;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; do_halt = 1; do_exe_reg_write = 0; exe_reg_addr = 0; is_mem_read = 0;
    is_mem_write = 0; do_branch = 0; result = 0; store_value = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // halt held for three cycles, then first ADD r3 <= 0x0012
    for (int i = 0; i < 3; i++) step("idle", 1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    step("add_r3", 0, 1, 4'd3, 0, 0, 0, 16'h0012, 16'h0);
    chk("add_r3.we_const", 32'(reg_we), 32'd1);
    chk("add_r3.data_const", 32'(reg_wdata), 32'h0012);
    chk("add_r3.cnt_const", 32'(retired_count), 32'd1);

    // populate every word; upper address bits are noise and must be ignored
    for (int i = 0; i < DEPTH; i++)
      step("fill", 0, 0, 0, 0, 1, 0, {8'($urandom), 8'(i)}, 16'($urandom));
    chk("fill.cnt_sat", 32'(retired_count), 32'd15);

    do_reset("reset2");
    step("st_beef", 0, 0, 0, 0, 1, 0, 16'h0005, 16'hBEEF);
    step("ld_r7", 0, 1, 4'd7, 1, 0, 0, 16'h0005, 16'h0);
    chk("ld_r7.data_const", 32'(reg_wdata), 32'hBEEF);
    chk("ld_r7.haz_const", 32'(is_mem_data_hazard), 32'd1);
    step("after_ld", 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("after_ld.hold", 32'(mem_value), 32'hBEEF);

    step("branch", 0, 1, 4'd9, 0, 1, 1, 16'h0020, 16'hDEAD);
    step("ld_20", 0, 1, 4'd1, 1, 0, 0, 16'h0020, 16'h0);

    step("rw_10", 0, 1, 4'd2, 1, 1, 0, 16'h0010, 16'h1234);
    step("ld_10", 0, 1, 4'd4, 1, 0, 0, 16'h0010, 16'h0);
    chk("ld_10.data_const", 32'(reg_wdata), 32'h1234);

    step("ld_norw", 0, 0, 4'd5, 1, 0, 0, 16'h0010, 16'h0);

    for (int i = 0; i < 300; i++)
      step("rand", 0, 1'($urandom), 4'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           16'($urandom), 16'($urandom));

    do_reset("reset3");
    step("run", 0, 1, 4'd1, 0, 0, 0, 16'h0077, 16'h0);
    step("halt", 1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    chk("halt.halted_const", 32'(wb_halted), 32'd1);
    step("halted_st", 0, 0, 0, 0, 1, 0, 16'h0030, 16'hFFFF);
    step("halted_add", 0, 1, 4'd6, 0, 0, 0, 16'h4321, 16'h0);
    step("halted_ld", 0, 1, 4'd6, 1, 0, 0, 16'h0030, 16'h0);

    do_reset("reset4");
    step("ld_30", 0, 1, 4'd8, 1, 0, 0, 16'h0030, 16'h0);
    step("st_42", 0, 0, 0, 0, 1, 0, 16'h0040, 16'h0042);
    step("ld_40", 0, 1, 4'd2, 1, 0, 0, 16'h0040, 16'h0);
    clk_run = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.mem_value0", 32'(mem_value), 32'd0);
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("ld_40_again", 0, 1, 4'd2, 1, 0, 0, 16'h0040, 16'h0);
    chk("retain.const", 32'(reg_wdata), 32'h0042);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
